// File: rtl/i2s_pkg.sv
// Shared constants, types and slot decoding for the I2S master transmitter.
// A frame is 64 bit clocks: two 32-bit slots, 24 data bits MSB-first plus 8 pad bits each.
package i2s_pkg;

    localparam int SMPL_BITS  = 24;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        LFT_DATA,
        LFT_PAD,
        RGHT_DATA,
        RGHT_PAD
    } slot_state_t;

    typedef logic [SMPL_BITS-1:0] smpl_t;

    // Slot is the top bit of the frame position; pad covers slot positions 24..31.
    function automatic slot_state_t slot_of(input logic [5:0] b);
        logic pad;
        pad = (b[4:0] >= 5'(SMPL_BITS));
        case ({b[5], pad})
            2'b00:   slot_of = LFT_DATA;
            2'b01:   slot_of = LFT_PAD;
            2'b10:   slot_of = RGHT_DATA;
            default: slot_of = RGHT_PAD;
        endcase
    endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: registered I2S_sclk (low for the first half of the count, high for the second)
// plus a one-clk fall_evt strobe on the cycle whose edge wraps the divider and drops sclk.
module i2s_sclk_gen #(
    parameter int SCLK_DIV = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic I2S_sclk,
    output logic fall_evt
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] PRE_RISE = CW'(SCLK_DIV / 2 - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          sclk_q, sclk_d;

    always_comb begin
        fall_evt  = (div_cnt_q == LAST_CNT);
        div_cnt_d = div_cnt_q + CW'(1);
        sclk_d    = sclk_q;
        if (fall_evt) begin
            div_cnt_d = '0;
            sclk_d    = 1'b0;
        end else if (div_cnt_q == PRE_RISE) begin
            // sclk goes high together with div_cnt reaching SCLK_DIV/2
            sclk_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign I2S_sclk = sclk_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: Philips format, 24-bit samples in 32-bit slots, one-deep shadow buffer.
// Optional I2S_TX_MUTE_ON_UNDERRUN_EN: an underrun sends a zero frame instead of repeating the last one.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] lft_chnnl,
    input  logic [23:0] rght_chnnl,
    input  logic        wrt_smpl,
    output logic        smpl_rdy,
    output logic        I2S_sclk,
    output logic        I2S_ws,
    output logic        I2S_data,
    output logic        underrun
);

    localparam int BW = $clog2(FRAME_BITS);

    logic          fall_evt;
    logic          frame_start;
    logic [BW-1:0] b;
    logic [4:0]    pos;
    logic [4:0]    bit_idx;

    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    slot_state_t   state_q, state_d;
    logic          full_q, full_d;
    smpl_t         shd_l_q, shd_l_d, shd_r_q, shd_r_d;
    smpl_t         sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic          ws_q, ws_d;
    logic          data_q, data_d;
    logic          underrun_q, underrun_d;

    i2s_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .I2S_sclk (I2S_sclk),
        .fall_evt (fall_evt)
    );

    always_comb begin
        b           = bit_cnt_q + BW'(1);
        pos         = b[4:0];
        bit_idx     = 5'(SMPL_BITS - 1) - pos;
        frame_start = fall_evt && (b == '0);

        bit_cnt_d  = bit_cnt_q;
        state_d    = state_q;
        full_d     = full_q;
        shd_l_d    = shd_l_q;
        shd_r_d    = shd_r_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        ws_d       = ws_q;
        data_d     = data_q;
        underrun_d = 1'b0;

        if (frame_start) begin
            if (full_q) begin
                sh_l_d = shd_l_q;
                sh_r_d = shd_r_q;
                full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                sh_l_d = '0;
                sh_r_d = '0;
`endif
            end
        end

        // Acceptance looks at the pre-load shadow state: no bypass into the frame being loaded.
        if (wrt_smpl && !full_q) begin
            shd_l_d = lft_chnnl;
            shd_r_d = rght_chnnl;
            full_d  = 1'b1;
        end

        if (fall_evt) begin
            bit_cnt_d = b;
            state_d   = slot_of(b);
            // WS leads the slot by one bit: high for b = 31..62.
            ws_d      = (b >= BW'(SLOT_BITS - 1)) && (b != BW'(FRAME_BITS - 1));
            case (state_d)
                LFT_DATA:  data_d = sh_l_d[bit_idx];
                RGHT_DATA: data_d = sh_r_d[bit_idx];
                default:   data_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= BW'(FRAME_BITS - 1);
            state_q    <= RGHT_PAD;
            full_q     <= 1'b0;
            shd_l_q    <= '0;
            shd_r_q    <= '0;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
            ws_q       <= 1'b0;
            data_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            state_q    <= state_d;
            full_q     <= full_d;
            shd_l_q    <= shd_l_d;
            shd_r_q    <= shd_r_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
            ws_q       <= ws_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
        end
    end

    assign smpl_rdy = ~full_q;
    assign I2S_ws   = ws_q;
    assign I2S_data = data_q;
    assign underrun = underrun_q;

endmodule
